// File: rtl/ahb_sram_pkg.sv
// Shared encodings for the AHB-lite SRAM slave: bus field values, FSM states
// and the byte-lane mask helper.
package ahb_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR1,
    ST_WR2,
    ST_RDW,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // Little-endian lane enables for a legal (already alignment-checked) transfer.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
    case (size)
      HSIZE_BYTE: lane_mask = 4'b0001 << addr;
      HSIZE_HALF: lane_mask = addr[1] ? 4'b1100 : 4'b0011;
      default:    lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_byte_merge.sv
// Byte-lane merge for read-modify-write: lanes with mask set come from new_data,
// the rest keep the old SRAM word.
module ahb_byte_merge (
  input  logic [31:0] old_data,
  input  logic [31:0] new_data,
  input  logic [3:0]  mask,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_data;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) merged[8*i +: 8] = new_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-lite slave front end for a single-port sync-read SRAM; sub-word writes are
// done as a fetch (WR1) followed by a merged word write (WR2).
module ahb_sram_slave
  import ahb_sram_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_data,
  output logic              sram_wren,
  input  logic [31:0]       sram_q
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        mask_q, mask_d;
  logic [31:0]       hwdata_q, hwdata_d;
  logic              accept, req_err;
  logic [31:0]       merged;
  logic              unused_inputs;

  // Bursts are treated beat by beat and aliasing above the SRAM is the decoder's job.
  assign unused_inputs = ^{HBURST, HTRANS[0], HADDR[31:ADDR_W+2]};

  assign accept  = HSEL & HREADY & HTRANS[1];
  assign req_err = (HSIZE > HSIZE_WORD)
                 | ((HSIZE == HSIZE_HALF) & HADDR[0])
                 | ((HSIZE == HSIZE_WORD) & (|HADDR[1:0]));

  ahb_byte_merge u_merge (
    .old_data (sram_q),
    .new_data (hwdata_q),
    .mask     (mask_q),
    .merged   (merged)
  );

  // NOTE: every output and _d signal gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    hwdata_d  = hwdata_q;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = 32'h0;
    sram_addr = addr_q;
    sram_data = 32'h0;
    sram_wren = 1'b0;

    case (state_q)
      ST_RD:  HRDATA = sram_q;
      ST_WR1: begin
        HREADYOUT = 1'b0;
        hwdata_d  = HWDATA;
        state_d   = ST_WR2;
      end
      ST_WR2: begin
        sram_wren = 1'b1;
        sram_data = (mask_q == 4'b1111) ? hwdata_q : merged;
      end
      ST_RDW: begin
        HREADYOUT = 1'b0;
        state_d   = ST_RD;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      ST_ERR2: HRESP = HRESP_ERROR;
      default: ;
    endcase

    // Every ready state ends its data phase here and decides on the next address phase.
    if (HREADYOUT) begin
      state_d = ST_IDLE;
      if (accept) begin
        if (req_err) begin
          state_d = ST_ERR1;
        end else begin
          addr_d = HADDR[ADDR_W+1:2];
          mask_d = lane_mask(HSIZE, HADDR[1:0]);
          if (HWRITE) begin
            state_d = ST_WR1;
          end else if (state_q == ST_WR2) begin
            state_d = ST_RDW;
          end else begin
            state_d   = ST_RD;
            sram_addr = HADDR[ADDR_W+1:2];
          end
        end
      end
    end
  end

  // NOTE: state uses non-blocking assignments; the async reset clears the FSM so sram_wren drops immediately.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      mask_q   <= '0;
      hwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      mask_q   <= mask_d;
      hwdata_q <= hwdata_d;
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: per-cycle vector table plus a reset-during-write sequence,
// with a behavioural sync-read SRAM attached.
module tb_ahb_sram_slave;
  import ahb_sram_pkg::*;

  localparam int ADDR_W = 10;

  logic              HCLK = 1'b0;
  logic              HRESETn = 1'b0;
  logic              HSEL = 1'b0;
  logic [31:0]       HADDR = '0;
  logic [1:0]        HTRANS = HTRANS_IDLE;
  logic              HWRITE = 1'b0;
  logic [2:0]        HSIZE = HSIZE_WORD;
  logic [2:0]        HBURST = '0;
  logic [31:0]       HWDATA = '0;
  logic              HREADY;
  logic              HREADYOUT;
  logic              HRESP;
  logic [31:0]       HRDATA;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_data;
  logic              sram_wren;
  logic [31:0]       sram_q;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahb_sram_slave #(.ADDR_W(ADDR_W)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .sram_addr (sram_addr),
    .sram_data (sram_data),
    .sram_wren (sram_wren),
    .sram_q    (sram_q)
  );

  // Sync-read SRAM model with a bench-side preload port.
  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [31:0]       pre_data = '0;

  always @(posedge HCLK) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (sram_wren) mem[sram_addr] <= sram_data;
    sram_q <= mem[sram_addr];
  end

  logic mon_en = 1'b0;
  int   wren_seen = 0;
  always @(posedge HCLK) if (mon_en && sram_wren) wren_seen <= wren_seen + 1;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        e_ready;
    logic        e_resp;
    logic [31:0] e_rdata;
    logic        e_wren;
    logic        chk_addr;
    logic [9:0]  e_addr;
    logic [31:0] e_sdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic sel, input logic [1:0] tr, input logic wr,
                             input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                             input logic rdy, input logic rsp, input logic [31:0] rd,
                             input logic wren, input logic ca, input logic [9:0] ea,
                             input logic [31:0] sd);
    vec_t r;
    r.sel = sel; r.trans = tr; r.write = wr; r.size = sz; r.addr = a; r.wdata = wd;
    r.e_ready = rdy; r.e_resp = rsp; r.e_rdata = rd; r.e_wren = wren;
    r.chk_addr = ca; r.e_addr = ea; r.e_sdata = sd;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input int a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a[ADDR_W-1:0]; pre_data = d;
    @(posedge HCLK); #1;
    pre_we = 1'b0;
  endtask

  // Drive one cycle of bus inputs, check outputs mid-cycle, then step past the edge.
  task automatic apply_vec(input vec_t x, input string tag);
    HSEL = x.sel; HTRANS = x.trans; HWRITE = x.write; HSIZE = x.size;
    HADDR = x.addr; HWDATA = x.wdata;
    @(negedge HCLK);
    check({tag, " hreadyout"}, {31'b0, HREADYOUT}, {31'b0, x.e_ready});
    check({tag, " hresp"},     {31'b0, HRESP},     {31'b0, x.e_resp});
    check({tag, " hrdata"},    HRDATA,             x.e_rdata);
    check({tag, " sram_wren"}, {31'b0, sram_wren}, {31'b0, x.e_wren});
    if (x.chk_addr) check({tag, " sram_addr"}, {22'b0, sram_addr}, {22'b0, x.e_addr});
    if (x.e_wren)   check({tag, " sram_data"}, sram_data, x.e_sdata);
    @(posedge HCLK); #1;
  endtask

  localparam logic [1:0] I = HTRANS_IDLE, B = HTRANS_BUSY, N = HTRANS_NONSEQ, S = HTRANS_SEQ;
  localparam logic [2:0] BY = HSIZE_BYTE, H = HSIZE_HALF, W = HSIZE_WORD;

  initial begin
    // Word write then read-after-write (RDW wait).
    vecs.push_back(v(1, N, 1, W, 32'h010, 32'h0,        1, 0, 32'h0,        0, 0, 0, 32'h0));
    vecs.push_back(v(1, I, 0, W, 32'h0,   32'hDEADBEEF, 0, 0, 32'h0,        0, 1, 4, 32'h0));
    vecs.push_back(v(1, N, 0, W, 32'h010, 32'h0,        1, 0, 32'h0,        1, 1, 4, 32'hDEADBEEF));
    vecs.push_back(v(1, I, 0, W, 32'h0,   32'h0,        0, 0, 32'h0,        0, 1, 4, 32'h0));
    // Byte write into lane 1, then halfword into lanes 3:2, back to back.
    vecs.push_back(v(1, N, 1, BY, 32'h005, 32'h0,       1, 0, 32'hDEADBEEF, 0, 0, 0, 32'h0));
    vecs.push_back(v(1, I, 0, W, 32'h0,   32'h0000AA00, 0, 0, 32'h0,        0, 1, 1, 32'h0));
    vecs.push_back(v(1, N, 1, H, 32'h006, 32'h0,        1, 0, 32'h0,        1, 1, 1, 32'h1122AA44));
    vecs.push_back(v(1, I, 0, W, 32'h0,   32'hBEEF0000, 0, 0, 32'h0,        0, 1, 1, 32'h0));
    vecs.push_back(v(1, I, 0, W, 32'h0,   32'h0,        1, 0, 32'h0,        1, 1, 1, 32'hBEEFAA44));
    // Back-to-back zero-wait reads.
    vecs.push_back(v(1, N, 0, W, 32'h000, 32'h0,        1, 0, 32'h0,        0, 1, 0, 32'h0));
    vecs.push_back(v(1, S, 0, W, 32'h004, 32'h0,        1, 0, 32'hCAFEF00D, 0, 1, 1, 32'h0));
    vecs.push_back(v(1, I, 0, W, 32'h0,   32'h0,        1, 0, 32'hBEEFAA44, 0, 0, 0, 32'h0));
    // Errors: HSIZE=3, then misaligned half, then a normal read after ERR2.
    vecs.push_back(v(1, N, 0, 3'd3, 32'h000, 32'h0,     1, 0, 32'h0,        0, 0, 0, 32'h0));
    vecs.push_back(v(1, I, 0, W, 32'h0,   32'h0,        0, 1, 32'h0,        0, 0, 0, 32'h0));
    vecs.push_back(v(1, N, 0, H, 32'h001, 32'h0,        1, 1, 32'h0,        0, 0, 0, 32'h0));
    vecs.push_back(v(1, I, 0, W, 32'h0,   32'h0,        0, 1, 32'h0,        0, 0, 0, 32'h0));
    vecs.push_back(v(1, N, 0, W, 32'h010, 32'h0,        1, 1, 32'h0,        0, 1, 4, 32'h0));
    // BUSY and unselected transfers are ignored; upper address bits alias.
    vecs.push_back(v(1, B, 1, W, 32'h00C, 32'h0,        1, 0, 32'hDEADBEEF, 0, 0, 0, 32'h0));
    vecs.push_back(v(0, N, 1, W, 32'h000, 32'h0,        1, 0, 32'h0,        0, 0, 0, 32'h0));
    vecs.push_back(v(1, N, 0, W, 32'h1000_0010, 32'h0,  1, 0, 32'h0,        0, 1, 4, 32'h0));
    vecs.push_back(v(1, I, 0, W, 32'h0,   32'h0,        1, 0, 32'hDEADBEEF, 0, 0, 0, 32'h0));
    // Misaligned word write must error without touching the SRAM.
    vecs.push_back(v(1, N, 1, W, 32'h002, 32'h0,        1, 0, 32'h0,        0, 0, 0, 32'h0));
    vecs.push_back(v(1, I, 0, W, 32'h0,   32'h55555555, 0, 1, 32'h0,        0, 0, 0, 32'h0));
    vecs.push_back(v(1, I, 0, W, 32'h0,   32'h0,        1, 1, 32'h0,        0, 0, 0, 32'h0));
    vecs.push_back(v(1, I, 0, W, 32'h0,   32'h0,        1, 0, 32'h0,        0, 0, 0, 32'h0));

    // Reset state, with SRAM preloaded while reset is held.
    preload(0, 32'hCAFEF00D);
    preload(1, 32'h11223344);
    preload(4, 32'h00000000);
    preload(8, 32'h08080808);
    @(negedge HCLK);
    check("reset hreadyout", {31'b0, HREADYOUT}, 32'h1);
    check("reset hresp",     {31'b0, HRESP},     32'h0);
    check("reset hrdata",    HRDATA,             32'h0);
    check("reset sram_wren", {31'b0, sram_wren}, 32'h0);
    check("reset sram_addr", {22'b0, sram_addr}, 32'h0);
    check("reset sram_data", sram_data,          32'h0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], $sformatf("v%0d", i));

    check("mem word0", mem[0], 32'hCAFEF00D);
    check("mem word1", mem[1], 32'hBEEFAA44);
    check("mem word4", mem[4], 32'hDEADBEEF);

    // Reset asserted during WR1 of a write to 0x020: the write must vanish.
    mon_en = 1'b1;
    apply_vec(v(1, N, 1, W, 32'h020, 32'h0, 1, 0, 32'h0, 0, 0, 0, 32'h0), "t6 addr");
    HSEL = 1'b1; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HWDATA = 32'h12345678;
    @(negedge HCLK);
    check("t6 wr1 hreadyout", {31'b0, HREADYOUT}, 32'h0);
    #2 HRESETn = 1'b0;
    #1;
    check("t6 rst sram_wren", {31'b0, sram_wren}, 32'h0);
    check("t6 rst hreadyout", {31'b0, HREADYOUT}, 32'h1);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    mon_en = 1'b0;
    check("t6 wren pulses", wren_seen, 32'h0);
    check("t6 mem word8", mem[8], 32'h08080808);
    apply_vec(v(1, N, 0, W, 32'h020, 32'h0, 1, 0, 32'h0,        0, 1, 8, 32'h0), "t6 rd addr");
    apply_vec(v(1, I, 0, W, 32'h0,   32'h0, 1, 0, 32'h08080808, 0, 0, 0, 32'h0), "t6 rd data");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
